// File: rtl/vx_commit_arbiter.sv
// Commit arbiter: merges execute-unit result packets into one registered writeback stream.
// Optional stall counter output perf_commit_stalls when COMMIT_PERF_EN is defined.
module vx_commit_arbiter #(
   parameter int NUM_REQS    = 5,
   parameter int NUM_THREADS = 4,
   parameter int NUM_WARPS   = 4,
   parameter int NR_BITS     = 5,
   parameter int DATA_W      = 32,
   parameter int UUID_W      = 44,
   parameter int PC_W        = 32
`ifdef COMMIT_PERF_EN
   ,
   parameter int PERF_CTR_BITS = 16
`endif
   ,
   localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQS-1:0]               req_valid,
   output logic [NUM_REQS-1:0]               req_ready,
   input  logic [NUM_REQS*UUID_W-1:0]        req_uuid,
   input  logic [NUM_REQS*WID_W-1:0]         req_wid,
   input  logic [NUM_REQS*PC_W-1:0]          req_pc,
   input  logic [NUM_REQS*NUM_THREADS-1:0]   req_tmask,
   input  logic [NUM_REQS-1:0]               req_wb,
   input  logic [NUM_REQS*NR_BITS-1:0]       req_rd,
   input  logic [NUM_REQS*NUM_THREADS*DATA_W-1:0] req_data,
   input  logic [NUM_REQS-1:0]               req_eop,
   output logic                              wb_valid,
   output logic [UUID_W-1:0]                 wb_uuid,
   output logic [WID_W-1:0]                  wb_wid,
   output logic [PC_W-1:0]                   wb_pc,
   output logic [NUM_THREADS-1:0]            wb_tmask,
   output logic [NR_BITS-1:0]                wb_rd,
   output logic [NUM_THREADS*DATA_W-1:0]     wb_data,
   output logic                              wb_eop
`ifdef COMMIT_PERF_EN
   ,
   output logic [PERF_CTR_BITS-1:0]          perf_commit_stalls
`endif
);

   localparam int IDX_W = $clog2(NUM_REQS);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] lock_src_q, lock_src_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_any;

   logic [UUID_W-1:0]             uuid_a  [NUM_REQS];
   logic [WID_W-1:0]              wid_a   [NUM_REQS];
   logic [PC_W-1:0]               pc_a    [NUM_REQS];
   logic [NUM_THREADS-1:0]        tmask_a [NUM_REQS];
   logic [NR_BITS-1:0]            rd_a    [NUM_REQS];
   logic [NUM_THREADS*DATA_W-1:0] data_a  [NUM_REQS];

   logic                          wb_valid_q, wb_eop_q;
   logic [UUID_W-1:0]             wb_uuid_q;
   logic [WID_W-1:0]              wb_wid_q;
   logic [PC_W-1:0]               wb_pc_q;
   logic [NUM_THREADS-1:0]        wb_tmask_q;
   logic [NR_BITS-1:0]            wb_rd_q;
   logic [NUM_THREADS*DATA_W-1:0] wb_data_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQS; gi++) begin : g_src
         assign uuid_a[gi]    = req_uuid[gi*UUID_W +: UUID_W];
         assign wid_a[gi]     = req_wid[gi*WID_W +: WID_W];
         assign pc_a[gi]      = req_pc[gi*PC_W +: PC_W];
         assign tmask_a[gi]   = req_tmask[gi*NUM_THREADS +: NUM_THREADS];
         assign rd_a[gi]      = req_rd[gi*NR_BITS +: NR_BITS];
         assign data_a[gi]    = req_data[gi*NUM_THREADS*DATA_W +: NUM_THREADS*DATA_W];
         assign req_ready[gi] = grant_any && (grant_idx == IDX_W'(gi));
      end
   endgenerate

   // Locked: only the owner may be granted. Idle: first valid at or after rr_ptr.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      if (!reset) begin
         if (state_q == LOCKED) begin
            grant_any = req_valid[lock_src_q];
            grant_idx = lock_src_q;
         end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
               idx = int'(rr_ptr_q) + k;
               if (idx >= NUM_REQS) idx = idx - NUM_REQS;
               if (!grant_any && req_valid[IDX_W'(idx)]) begin
                  grant_any = 1'b1;
                  grant_idx = IDX_W'(idx);
               end
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_src_d = lock_src_q;
      rr_ptr_d   = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
         if (state_q == IDLE && !req_eop[grant_idx]) begin
            state_d    = LOCKED;
            lock_src_d = grant_idx;
         end else if (state_q == LOCKED && req_eop[grant_idx]) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         lock_src_q <= '0;
         rr_ptr_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_eop_q   <= 1'b0;
         wb_uuid_q  <= '0;
         wb_wid_q   <= '0;
         wb_pc_q    <= '0;
         wb_tmask_q <= '0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         lock_src_q <= lock_src_d;
         rr_ptr_q   <= rr_ptr_d;
         // A non-writing eop still emits an empty-mask packet so the scoreboard releases the warp.
         wb_valid_q <= grant_any && (req_wb[grant_idx] || req_eop[grant_idx]);
         wb_eop_q   <= grant_any && req_eop[grant_idx];
         if (grant_any) begin
            wb_uuid_q  <= uuid_a[grant_idx];
            wb_wid_q   <= wid_a[grant_idx];
            wb_pc_q    <= pc_a[grant_idx];
            wb_tmask_q <= req_wb[grant_idx] ? tmask_a[grant_idx] : '0;
            wb_rd_q    <= rd_a[grant_idx];
            wb_data_q  <= data_a[grant_idx];
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_eop   = wb_eop_q;
   assign wb_uuid  = wb_uuid_q;
   assign wb_wid   = wb_wid_q;
   assign wb_pc    = wb_pc_q;
   assign wb_tmask = wb_tmask_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;

`ifdef COMMIT_PERF_EN
   logic [PERF_CTR_BITS-1:0] perf_q;
   logic                     multi_valid, lock_block;

   assign multi_valid = |(req_valid & (req_valid - 1'b1));
   assign lock_block  = (state_q == LOCKED) &&
                        |(req_valid & ~(NUM_REQS'(1) << lock_src_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_q <= '0;
      end else if ((multi_valid || lock_block) && !(&perf_q)) begin
         perf_q <= perf_q + 1'b1;
      end
   end

   assign perf_commit_stalls = perf_q;
`endif

endmodule
